fcvt_seq: RTL and testbench

Multi-cycle, handshaked float/int conversion unit for the FPU. It converts IEEE-754 single precision to a signed 32-bit integer (ftoi), or a signed 32-bit integer to single precision (itof). Normalization and alignment run through a one-bit-per-cycle shifter, trading latency for area. It sits behind the FPU issue stage and uses valid/ready handshakes on both sides, so long-latency conversions can stall issue without blocking writeback.

---
 rtl/fcvt_seq.sv | 144 ++++++++++++++
 tb/tb_fcvt_seq.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/fcvt_seq.sv
// Sequential float<->int converter: single-precision to int32 (ftoi) and int32 to
// single-precision (itof), round to nearest with ties away from zero, one shift per cycle.
module fcvt_seq (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_op,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
);

  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] m_q, m_d;
  logic        g_q, g_d;
  logic        s_q, s_d;
  logic        op_q, op_d;
  logic        left_q, left_d;
  logic [4:0]  n_q, n_d;
  logic [4:0]  nl_q, nl_d;
  logic [31:0] out_q, out_d;

  logic [7:0]  exp_in;
  logic [31:0] abs_val;
  logic [4:0]  lz;
  logic [31:0] mag;
  logic [23:0] frac25;
  logic [7:0]  exp_out;

  assign exp_in = in_data[30:23];
  assign abs_val = in_data[31] ? (~in_data + 32'd1) : in_data;

  // Index of the highest set bit wins, giving the leading-zero count.
  always_comb begin
    lz = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (abs_val[i]) lz = 5'(31 - i);
    end
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    g_d     = g_q;
    s_d     = s_q;
    op_d    = op_q;
    left_d  = left_q;
    n_d     = n_q;
    nl_d    = nl_q;
    out_d   = out_q;
    mag     = m_q + {31'd0, g_q};
    frac25  = {1'b0, m_q[30:8]} + {23'd0, m_q[7]};
    exp_out = 8'd158 - {3'd0, nl_q};

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d   = in_op;
          g_d    = 1'b0;
          s_d    = in_data[31];
          left_d = 1'b1;
          n_d    = 5'd0;
          if (in_op) begin
            m_d  = abs_val;
            n_d  = lz;
          end else if (exp_in < 8'd126) begin
            m_d  = 32'd0;
          end else if (exp_in >= 8'd158) begin
            // Negating 0x80000000 leaves it unchanged, so both saturation values fall out of ROUND.
            m_d  = in_data[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
          end else if (exp_in < 8'd150) begin
            m_d    = {8'd0, 1'b1, in_data[22:0]};
            n_d    = 5'(8'd150 - exp_in);
            left_d = 1'b0;
          end else begin
            m_d  = {8'd0, 1'b1, in_data[22:0]};
            n_d  = 5'(exp_in - 8'd150);
          end
          nl_d    = n_d;
          state_d = (n_d == 5'd0) ? ROUND : SHIFT;
        end
      end
      SHIFT: begin
        if (left_q) begin
          m_d = {m_q[30:0], 1'b0};
        end else begin
          m_d = {1'b0, m_q[31:1]};
          g_d = m_q[0];
        end
        n_d = n_q - 5'd1;
        if (n_q == 5'd1) state_d = ROUND;
      end
      ROUND: begin
        if (!op_q) begin
          out_d = s_q ? (~mag + 32'd1) : mag;
        end else if (!m_q[31]) begin
          out_d = 32'd0;
        end else if (frac25[23]) begin
          out_d = {s_q, exp_out + 8'd1, 23'd0};
        end else begin
          out_d = {s_q, exp_out, frac25[22:0]};
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      m_q     <= 32'd0;
      g_q     <= 1'b0;
      s_q     <= 1'b0;
      op_q    <= 1'b0;
      left_q  <= 1'b0;
      n_q     <= 5'd0;
      nl_q    <= 5'd0;
      out_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      g_q     <= g_d;
      s_q     <= s_d;
      op_q    <= op_d;
      left_q  <= left_d;
      n_q     <= n_d;
      nl_q    <= nl_d;
      out_q   <= out_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = out_q;

endmodule

// File: tb/tb_fcvt_seq.sv
// Directed bench for fcvt_seq: expected result and latency are queued at accept time
// and compared when out_valid rises; also covers backpressure and mid-conversion reset.
module tb_fcvt_seq;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_op = 1'b0;
  logic [31:0] in_data = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_data_q[$];
  int          exp_lat_q[$];

  fcvt_seq dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int expv);
    checks++;
    assert (obs == expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic convert(input logic op, input logic [31:0] d, input logic [31:0] expd,
                         input int expl, input bit hold);
    int lat;
    int waitc;
    logic [31:0] ed;
    int el;
    out_ready = !hold;
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    waitc = 0;
    while (!in_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    check32("accept_ready", {31'd0, in_ready}, 32'd1);
    exp_data_q.push_back(expd);
    exp_lat_q.push_back(expl);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_op    = ~op;
    in_data  = $urandom;
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    ed = exp_data_q.pop_front();
    el = exp_lat_q.pop_front();
    check32("result", out_data, ed);
    check_int("latency", lat, el);
    $display("op=%0d in=%h out=%h exp=%h lat=%0d", op, d, out_data, ed, lat);
    if (hold) begin
      for (int i = 0; i < 10; i++) begin
        @(posedge clk);
        #1;
        check32("bp_valid", {31'd0, out_valid}, 32'd1);
        check32("bp_data", out_data, ed);
        check32("bp_in_ready", {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check32("post_ready", {31'd0, in_ready}, 32'd1);
    check32("post_valid", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int seen;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check32("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check32("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check32("rst_out_data", out_data, 32'd0);
    rstn = 1'b1;

    convert(1'b0, 32'h4020_0000, 32'h0000_0003, 24, 1'b0);
    convert(1'b0, 32'hC020_0000, 32'hFFFF_FFFD, 24, 1'b0);
    convert(1'b0, 32'h3F00_0000, 32'h0000_0001, 26, 1'b0);
    convert(1'b0, 32'h3EFF_FFFF, 32'h0000_0000, 2, 1'b0);
    convert(1'b0, 32'h4F00_0000, 32'h7FFF_FFFF, 2, 1'b0);
    convert(1'b0, 32'hCF00_0000, 32'h8000_0000, 2, 1'b0);
    convert(1'b0, 32'h7F80_0000, 32'h7FFF_FFFF, 2, 1'b0);
    convert(1'b0, 32'h4B00_0000, 32'h0080_0000, 2, 1'b0);
    convert(1'b0, 32'h4E80_0001, 32'h4000_0080, 9, 1'b0);
    convert(1'b0, 32'hCE80_0001, 32'hBFFF_FF80, 9, 1'b0);

    convert(1'b1, 32'h0000_0001, 32'h3F80_0000, 33, 1'b0);
    convert(1'b1, 32'hFFFF_FFFF, 32'hBF80_0000, 33, 1'b0);
    convert(1'b1, 32'h0000_0000, 32'h0000_0000, 2, 1'b0);
    convert(1'b1, 32'h8000_0000, 32'hCF00_0000, 2, 1'b0);
    convert(1'b1, 32'h7FFF_FFFF, 32'h4F00_0000, 3, 1'b0);
    convert(1'b1, 32'h0100_0001, 32'h4B80_0001, 9, 1'b0);
    convert(1'b1, 32'h0100_0003, 32'h4B80_0002, 9, 1'b0);

    convert(1'b1, 32'h0000_0003, 32'h4040_0000, 32, 1'b1);

    // Reset in the middle of an itof of 1; no result may surface afterwards.
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = 1'b1;
    in_data  = 32'h0000_0001;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    check32("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check32("midrst_out_data", out_data, 32'd0);
    check32("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rstn = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check_int("no_stale_result", seen, 0);
    $display("reset mid-shift: stale results seen=%0d", seen);

    convert(1'b1, 32'hFFFF_FFFE, 32'hC000_0000, 32, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
